// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: decode-stage register file with NUM_RD combinational read
// ports, two write ports (ALU and load writeback) and a per-register busy
// scoreboard for RAW hazard detection.
// Optional feature macro: RF_ZERO_REG_EN (register 0 hardwired to zero,
// never written, never bypassed, never busy).
module rf_multiport_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned NUM_RD = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_sel_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wr0_en_i,
   input  logic [ADDR_W-1:0]        wr0_sel_i,
   input  logic [DATA_W-1:0]        wr0_data_i,
   input  logic                     wr1_en_i,
   input  logic [ADDR_W-1:0]        wr1_sel_i,
   input  logic [DATA_W-1:0]        wr1_data_i,
   input  logic                     issue_en_i,
   input  logic [ADDR_W-1:0]        issue_sel_i,
   output logic [DEPTH-1:0]         busy_vec_o
);

`ifdef RF_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              wr0_act;
   logic              wr1_act;

   // Effective write strobes: writes to a hardwired zero register are dropped.
   always_comb begin
      wr0_act = wr0_en_i;
      wr1_act = wr1_en_i;
      if (ZERO_REG && (wr0_sel_i == '0)) wr0_act = 1'b0;
      if (ZERO_REG && (wr1_sel_i == '0)) wr1_act = 1'b0;
   end

   // Scoreboard next state: writeback clears, issue sets, and set wins a race.
   always_comb begin
      busy_d = busy_q;
      if (wr0_en_i)   busy_d[wr0_sel_i]   = 1'b0;
      if (wr1_en_i)   busy_d[wr1_sel_i]   = 1'b0;
      if (issue_en_i) busy_d[issue_sel_i] = 1'b1;
      if (ZERO_REG)   busy_d[0]           = 1'b0;
   end

   // Storage and scoreboard update; port 1 is written last so it wins a collision.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         busy_q <= '0;
      end else begin
         if (wr0_act) mem[wr0_sel_i] <= wr0_data_i;
         if (wr1_act) mem[wr1_sel_i] <= wr1_data_i;
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

   // Per-port read path: write-port bypass (port 1 first), then storage.
   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [ADDR_W-1:0] sel;
      logic              hit0;
      logic              hit1;
      logic              zero_sel;

      assign sel      = rd_sel_i[k*ADDR_W +: ADDR_W];
      assign hit0     = wr0_act && (wr0_sel_i == sel);
      assign hit1     = wr1_act && (wr1_sel_i == sel);
      assign zero_sel = ZERO_REG && (sel == '0);

      assign rd_data_o[k*DATA_W +: DATA_W] = zero_sel ? '0         :
                                             hit1     ? wr1_data_i :
                                             hit0     ? wr0_data_i :
                                                        mem[sel];
      // A same-cycle writeback resolves the hazard through the bypass.
      assign rd_busy_o[k] = busy_q[sel] && !hit0 && !hit1;
   end

endmodule
